// File: rtl/wb_arbiter_stage.sv
// wb_arbiter_stage: merges N_CH independent writeback result channels into the
// single register-file write port. Each channel selects its result on entry,
// buffers {rd, result} in a small FIFO, and an arbiter drains one entry per cycle
// into registered reg_write_out / rd_out / result_out.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; when undefined
// the arbiter is fixed priority (lowest channel index wins).
// result_src_e is 3 bits wide; encodings 4..7 are illegal and select 0.

package wb_arbiter_pkg;
    localparam int RSRC_BITS = 3;

    typedef enum logic [RSRC_BITS-1:0] {
        FROM_ALU     = 3'd0,
        FROM_CACHE   = 3'd1,
        FROM_PC_NEXT = 3'd2,
        FROM_AUIPC   = 3'd3
    } result_src_e;
endpackage

module wb_arbiter_stage
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int N_CH       = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_in,
    input  logic [N_CH-1:0]           valid_in,
    output logic [N_CH-1:0]           ready_out,
    input  logic [N_CH*XLEN-1:0]      alu_res_in,
    input  logic [N_CH*XLEN-1:0]      read_data_in,
    input  logic [N_CH*XLEN-1:0]      pc_plus4_in,
    input  logic [N_CH*XLEN-1:0]      pc_delta_in,
    input  logic [N_CH*RSRC_BITS-1:0] result_src_in,
    input  logic [N_CH*REG_BITS-1:0]  rd_in,
    input  logic [N_CH-1:0]           reg_write_in,
    output logic                      reg_write_out,
    output logic [REG_BITS-1:0]       rd_out,
    output logic [XLEN-1:0]           result_out,
    output logic                      busy_out
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ENT_W = REG_BITS + XLEN;

    logic [ENT_W-1:0]    fifo_mem_r [N_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r   [N_CH];
    logic [PTR_W-1:0]    rd_ptr_r   [N_CH];
    logic [CNT_W-1:0]    count_r    [N_CH];
    logic [ENT_W-1:0]    push_data_s[N_CH];
    logic [N_CH-1:0]     ready_s;
    logic [N_CH-1:0]     nonempty_s;
    logic [N_CH-1:0]     push_s;
    logic [N_CH-1:0]     pop_s;
    logic                grant_valid_s;
    logic [CH_W-1:0]     grant_idx_s;
    logic [ENT_W-1:0]    head_s;
    logic                reg_write_r;
    logic [REG_BITS-1:0] rd_r;
    logic [XLEN-1:0]     result_r;

    // Per-channel result mux applied at the channel boundary.
    function automatic logic [XLEN-1:0] select_result(
        input logic [RSRC_BITS-1:0] src,
        input logic [XLEN-1:0]      alu_res,
        input logic [XLEN-1:0]      read_data,
        input logic [XLEN-1:0]      pc_plus4,
        input logic [XLEN-1:0]      pc_delta
    );
        logic [XLEN-1:0] res;
        case (src)
            FROM_ALU:     res = alu_res;
            FROM_CACHE:   res = read_data;
            FROM_PC_NEXT: res = pc_plus4;
            FROM_AUIPC:   res = pc_delta;
            default:      res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    // Circular pointer advance modulo FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Channel status from registered counts, plus push qualification and entry data.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ready_s[c]     = (count_r[c] < CNT_W'(FIFO_DEPTH));
            nonempty_s[c]  = (count_r[c] != {CNT_W{1'b0}});
            push_s[c]      = valid_in[c] & ready_s[c] & reg_write_in[c]
                           & (rd_in[c*REG_BITS +: REG_BITS] != {REG_BITS{1'b0}})
                           & ~flush_in & ~reset;
            push_data_s[c] = {rd_in[c*REG_BITS +: REG_BITS],
                              select_result(result_src_in[c*RSRC_BITS +: RSRC_BITS],
                                            alu_res_in[c*XLEN +: XLEN],
                                            read_data_in[c*XLEN +: XLEN],
                                            pc_plus4_in[c*XLEN +: XLEN],
                                            pc_delta_in[c*XLEN +: XLEN])};
        end
    end

`ifdef WB_ARB_RR_EN
    logic [CH_W-1:0] last_grant_r;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [CH_W-1:0] cand;
        cand          = {CH_W{1'b0}};
        grant_valid_s = 1'b0;
        grant_idx_s   = {CH_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            cand = CH_W'((int'(last_grant_r) + 1 + i) % N_CH);
            if (!grant_valid_s && nonempty_s[cand]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // last_grant moves only on a real grant; flush leaves it alone, reset points it at N_CH-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= CH_W'(N_CH - 1);
        end else if (flush_in) begin
            last_grant_r <= last_grant_r;
        end else if (grant_valid_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: lowest non-empty channel index wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {CH_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (!grant_valid_s && nonempty_s[i]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = CH_W'(i);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end
`endif

    // Pop strobes for the granted channel and its head entry.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            pop_s[c] = grant_valid_s & (grant_idx_s == CH_W'(c)) & ~flush_in & ~reset;
        end
        head_s = fifo_mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
    end

    // FIFO storage write; contents need no reset because counts gate visibility.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push_s[c]) begin
                fifo_mem_r[c][wr_ptr_r[c]] <= push_data_s[c];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (reset || flush_in) begin
                wr_ptr_r[c] <= {PTR_W{1'b0}};
                rd_ptr_r[c] <= {PTR_W{1'b0}};
                count_r[c]  <= {CNT_W{1'b0}};
            end else begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= next_ptr(wr_ptr_r[c]);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= next_ptr(rd_ptr_r[c]);
                end
                case ({push_s[c], pop_s[c]})
                    2'b10:   count_r[c] <= count_r[c] + CNT_W'(1);
                    2'b01:   count_r[c] <= count_r[c] - CNT_W'(1);
                    default: count_r[c] <= count_r[c];
                endcase
            end
        end
    end

    // Output register: load the granted head, otherwise drop the write enable and hold data.
    always_ff @(posedge clk) begin
        if (reset || flush_in) begin
            reg_write_r <= 1'b0;
            rd_r        <= {REG_BITS{1'b0}};
            result_r    <= {XLEN{1'b0}};
        end else if (grant_valid_s) begin
            reg_write_r <= 1'b1;
            rd_r        <= head_s[ENT_W-1 -: REG_BITS];
            result_r    <= head_s[XLEN-1:0];
        end else begin
            reg_write_r <= 1'b0;
        end
    end

    assign ready_out     = ready_s;
    assign reg_write_out = reg_write_r;
    assign rd_out        = rd_r;
    assign result_out    = result_r;
    assign busy_out      = (|nonempty_s) | reg_write_r;

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed testbench for wb_arbiter_stage (N_CH=2, FIFO_DEPTH=2, XLEN=32).
// Operand buses carry fixed per-channel constants so every expected result is
// known by hand; a vector table covers result selection and filtering, and
// hand-written sequences cover contention, backpressure, flush and reset.
module tb_wb_arbiter_stage;
    localparam logic [2:0] S_ALU   = 3'd0;
    localparam logic [2:0] S_CACHE = 3'd1;
    localparam logic [2:0] S_PCN   = 3'd2;
    localparam logic [2:0] S_AUIPC = 3'd3;
    localparam logic [2:0] S_ILL5  = 3'd5;
    localparam logic [2:0] S_ILL7  = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_in;
    logic [1:0]  valid_in;
    logic [1:0]  ready_out;
    logic [63:0] alu_res_in;
    logic [63:0] read_data_in;
    logic [63:0] pc_plus4_in;
    logic [63:0] pc_delta_in;
    logic [5:0]  result_src_in;
    logic [9:0]  rd_in;
    logic [1:0]  reg_write_in;
    logic        reg_write_out;
    logic [4:0]  rd_out;
    logic [31:0] result_out;
    logic        busy_out;

    int n_pass  = 0;
    int n_total = 0;

    wb_arbiter_stage #(.XLEN(32), .REG_BITS(5), .N_CH(2), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .alu_res_in(alu_res_in), .read_data_in(read_data_in),
        .pc_plus4_in(pc_plus4_in), .pc_delta_in(pc_delta_in),
        .result_src_in(result_src_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .reg_write_out(reg_write_out), .rd_out(rd_out), .result_out(result_out),
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [2:0]  src0;
        logic [4:0]  rd0;
        logic [2:0]  src1;
        logic [4:0]  rd1;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        logic [1:0]  e_ready;
        logic        e_busy;
    } vec_t;

    vec_t vec [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [2:0] s0, input logic [4:0] r0,
                         input logic [2:0] s1, input logic [4:0] r1);
        valid_in      = v;
        reg_write_in  = we;
        result_src_in = {s1, s0};
        rd_in         = {r1, r0};
    endtask

    task automatic chk_out(input string name, input logic we, input logic [4:0] rd,
                           input logic [31:0] res);
        chk({name, "_we"}, {31'd0, reg_write_out}, {31'd0, we});
        chk({name, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        chk({name, "_res"}, result_out, res);
    endtask

    initial begin
        int q0[$];
        int q1[$];
        int i0;
        int i1;
        int pops;
        int stale;
        logic [1:0] rdy;
        logic [1:0] vld;

        // ch0: alu 0x11, read 0xAA, pc+4 0x104, pc_delta 0x2000
        // ch1: alu 0x33, read 0x44, pc+4 0x208, pc_delta 0xBB
        alu_res_in   = {32'h33, 32'h11};
        read_data_in = {32'h44, 32'hAA};
        pc_plus4_in  = {32'h208, 32'h104};
        pc_delta_in  = {32'hBB, 32'h2000};
        reset        = 1'b1;
        flush_in     = 1'b0;
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);

        step();
        step();
        chk_out("reset", 1'b0, 5'd0, 32'h0);
        chk("reset_ready", {30'd0, ready_out}, 32'h3);
        chk("reset_busy", {31'd0, busy_out}, 32'h0);
        reset = 1'b0;

        //          valid  we     src0     rd0    src1     rd1     we    rd     res         ready  busy
        vec[0]  = '{2'b01, 2'b01, S_ALU,   5'd5,  S_ALU,   5'd0,  1'b0, 5'd0,  32'h0,     2'b11, 1'b1};
        vec[1]  = '{2'b00, 2'b00, S_ALU,   5'd0,  S_ALU,   5'd0,  1'b1, 5'd5,  32'h11,    2'b11, 1'b1};
        vec[2]  = '{2'b00, 2'b00, S_ALU,   5'd0,  S_ALU,   5'd0,  1'b0, 5'd5,  32'h11,    2'b11, 1'b0};
        vec[3]  = '{2'b01, 2'b01, S_CACHE, 5'd7,  S_ALU,   5'd0,  1'b0, 5'd5,  32'h11,    2'b11, 1'b1};
        vec[4]  = '{2'b01, 2'b01, S_PCN,   5'd8,  S_ALU,   5'd0,  1'b1, 5'd7,  32'hAA,    2'b11, 1'b1};
        vec[5]  = '{2'b01, 2'b01, S_AUIPC, 5'd9,  S_ALU,   5'd0,  1'b1, 5'd8,  32'h104,   2'b11, 1'b1};
        vec[6]  = '{2'b01, 2'b01, S_ILL5,  5'd10, S_ALU,   5'd0,  1'b1, 5'd9,  32'h2000,  2'b11, 1'b1};
        vec[7]  = '{2'b10, 2'b10, S_ALU,   5'd0,  S_ALU,   5'd12, 1'b1, 5'd10, 32'h0,     2'b11, 1'b1};
        vec[8]  = '{2'b10, 2'b10, S_ALU,   5'd0,  S_AUIPC, 5'd13, 1'b1, 5'd12, 32'h33,    2'b11, 1'b1};
        vec[9]  = '{2'b11, 2'b10, S_ALU,   5'd14, S_CACHE, 5'd0,  1'b1, 5'd13, 32'hBB,    2'b11, 1'b1};
        vec[10] = '{2'b00, 2'b00, S_ALU,   5'd0,  S_ALU,   5'd0,  1'b0, 5'd13, 32'hBB,    2'b11, 1'b0};
        vec[11] = '{2'b01, 2'b01, S_ILL7,  5'd31, S_ALU,   5'd0,  1'b0, 5'd13, 32'hBB,    2'b11, 1'b1};
        vec[12] = '{2'b00, 2'b00, S_ALU,   5'd0,  S_ALU,   5'd0,  1'b1, 5'd31, 32'h0,     2'b11, 1'b1};
        vec[13] = '{2'b00, 2'b00, S_ALU,   5'd0,  S_ALU,   5'd0,  1'b0, 5'd31, 32'h0,     2'b11, 1'b0};

        for (int k = 0; k < 14; k++) begin
            drive(vec[k].valid, vec[k].we, vec[k].src0, vec[k].rd0, vec[k].src1, vec[k].rd1);
            step();
            chk_out($sformatf("vec%0d", k), vec[k].e_we, vec[k].e_rd, vec[k].e_res);
            chk($sformatf("vec%0d_ready", k), {30'd0, ready_out}, {30'd0, vec[k].e_ready});
            chk($sformatf("vec%0d_busy", k), {31'd0, busy_out}, {31'd0, vec[k].e_busy});
        end

        // Reset dominates a coincident flush and all-valid inputs.
        reset    = 1'b1;
        flush_in = 1'b1;
        drive(2'b11, 2'b11, S_CACHE, 5'd3, S_AUIPC, 5'd4);
        step();
        chk_out("rst_flush", 1'b0, 5'd0, 32'h0);
        chk("rst_flush_ready", {30'd0, ready_out}, 32'h3);
        chk("rst_flush_busy", {31'd0, busy_out}, 32'h0);

        // Contended pair: ch0 wins first in both builds right after reset.
        reset    = 1'b0;
        flush_in = 1'b0;
        step();
        chk("pair1_acc_we", {31'd0, reg_write_out}, 32'h0);
        chk("pair1_acc_busy", {31'd0, busy_out}, 32'h1);
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);
        step();
        chk_out("pair1_a", 1'b1, 5'd3, 32'hAA);
        step();
        chk_out("pair1_b", 1'b1, 5'd4, 32'hBB);
        step();
        chk("pair1_idle_we", {31'd0, reg_write_out}, 32'h0);
        chk("pair1_idle_busy", {31'd0, busy_out}, 32'h0);

        // A solo ch0 grant, then a second pair: round-robin now favours ch1.
        drive(2'b01, 2'b01, S_ALU, 5'd6, S_ALU, 5'd0);
        step();
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);
        step();
        chk_out("solo", 1'b1, 5'd6, 32'h11);
        drive(2'b11, 2'b11, S_CACHE, 5'd20, S_AUIPC, 5'd21);
        step();
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);
        step();
`ifdef WB_ARB_RR_EN
        chk_out("pair2_a", 1'b1, 5'd21, 32'hBB);
        step();
        chk_out("pair2_b", 1'b1, 5'd20, 32'hAA);
`else
        chk_out("pair2_a", 1'b1, 5'd20, 32'hAA);
        step();
        chk_out("pair2_b", 1'b1, 5'd21, 32'hBB);
`endif
        step();
        chk("pair2_idle_we", {31'd0, reg_write_out}, 32'h0);

        // ch0 floods six entries while ch1 offers three held-until-accepted entries.
        i0   = 0;
        i1   = 0;
        pops = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            drive({(i1 < 3), (i0 < 6)}, 2'b11, S_ALU, 5'(1 + i0), S_ALU, 5'(16 + i1));
            rdy = ready_out;
            vld = valid_in;
            step();
            if (vld[0] && rdy[0]) begin
                q0.push_back(1 + i0);
                i0++;
            end
            if (vld[1] && rdy[1]) begin
                q1.push_back(16 + i1);
                i1++;
            end
`ifndef WB_ARB_RR_EN
            if (cyc >= 1 && cyc <= 5) begin
                chk($sformatf("flood_ready_c%0d", cyc), {30'd0, ready_out}, 32'h1);
            end
`endif
            if (reg_write_out) begin
                pops++;
                if (rd_out >= 5'd16) begin
                    chk("flood_ch1_pending", {31'd0, (q1.size() > 0)}, 32'h1);
                    if (q1.size() > 0) begin
                        chk("flood_ch1_order", {27'd0, rd_out}, q1.pop_front());
                    end
                    chk("flood_ch1_res", result_out, 32'h33);
                end else begin
                    chk("flood_ch0_pending", {31'd0, (q0.size() > 0)}, 32'h1);
                    if (q0.size() > 0) begin
                        chk("flood_ch0_order", {27'd0, rd_out}, q0.pop_front());
                    end
                    chk("flood_ch0_res", result_out, 32'h11);
                end
            end
        end
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);
        chk("flood_accepts", i0 + i1, 32'd9);
        chk("flood_pops", pops, 32'd9);
        chk("flood_left", q0.size() + q1.size(), 32'd0);

        // Fill both FIFOs, then flush while new inputs are also offered.
        drive(2'b11, 2'b11, S_ALU, 5'd1, S_ALU, 5'd17);
        step();
        drive(2'b11, 2'b11, S_ALU, 5'd2, S_ALU, 5'd18);
        step();
        flush_in = 1'b1;
        drive(2'b11, 2'b11, S_ALU, 5'd3, S_ALU, 5'd19);
        step();
        flush_in = 1'b0;
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);
        chk_out("flush", 1'b0, 5'd0, 32'h0);
        chk("flush_ready", {30'd0, ready_out}, 32'h3);
        chk("flush_busy", {31'd0, busy_out}, 32'h0);
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (reg_write_out || busy_out) begin
                stale++;
            end
        end
        chk("no_stale", stale, 32'd0);

        // Channel 1 still works normally after the flush.
        drive(2'b10, 2'b10, S_ALU, 5'd0, S_PCN, 5'd9);
        step();
        drive(2'b00, 2'b00, S_ALU, 5'd0, S_ALU, 5'd0);
        step();
        chk_out("post_flush", 1'b1, 5'd9, 32'h208);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
